// File: rtl/muldiv_alu_ctrl.sv
// muldiv_alu_ctrl: EX-stage ALU controller with an iterative RV32M-style
// multiply/divide unit.
//
// Ports:
//   clk        - single clock, rising edge
//   reset      - asynchronous active-low reset
//   ALUOp      - controller class (00 LW/SW/AUIPC, 01 branch, 10 R/I, 11 JAL/LUI)
//   Funct7     - instruction bits 31:25
//   Funct3     - instruction bits 14:12
//   in_valid   - instruction in EX is valid
//   flush      - synchronous abort of any in-flight multiply/divide
//   SrcA, SrcB - rs1 / rs2 operands
//   Operation  - base ALU operation select (combinational)
//   md_sel     - EX result mux takes md_result instead of the base ALU
//   stall      - hold IF/ID/EX pipeline registers
//   md_done    - md_result valid this cycle (one cycle, in DONE)
//   md_result  - multiply/divide result, held outside DONE
//   dbg_state  - current FSM state (00 IDLE, 01 MUL, 10 DIV, 11 DONE)
//
// Handshake: an M-op is offered when in_valid is high; the unit accepts it in
// IDLE and keeps stall high until the result cycle (DONE), where stall drops
// and md_done is high so the instruction retires in that same cycle. The
// offering stage must hold the instruction stable while stall is high.
module muldiv_alu_ctrl #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [1:0]      ALUOp,
  input  logic [6:0]      Funct7,
  input  logic [2:0]      Funct3,
  input  logic            in_valid,
  input  logic            flush,
  input  logic [XLEN-1:0] SrcA,
  input  logic [XLEN-1:0] SrcB,
  output logic [3:0]      Operation,
  output logic            md_sel,
  output logic            stall,
  output logic            md_done,
  output logic [XLEN-1:0] md_result,
  output logic [1:0]      dbg_state
);

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_MUL  = 2'b01;
  localparam logic [1:0] S_DIV  = 2'b10;
  localparam logic [1:0] S_DONE = 2'b11;

  localparam int CW = $clog2(XLEN) + 1;

  logic [1:0]        r_state;
  logic [CW-1:0]     r_cnt;
  logic [2*XLEN-1:0] r_acc;
  logic [XLEN-1:0]   r_opb;
  logic [2:0]        r_f3;
  logic              r_neg_q;
  logic              r_neg_r;
  logic [XLEN-1:0]   r_md_result;

  // Base ALU decode
  always_comb begin
    Operation = 4'b0000;
    case (ALUOp)
      2'b00: Operation = 4'b0010;
      2'b01: Operation = 4'b0110;
      2'b10: begin
        if (Funct3 == 3'b000 && Funct7 != 7'b0000001)
          Operation = 4'b0010;
        else if (Funct3 == 3'b010 && Funct7 == 7'b0000000)
          Operation = 4'b1100;
      end
      default: Operation = 4'b0000;
    endcase
  end

  logic w_mop, w_start, w_div, w_a_signed, w_b_signed, w_sa, w_sb;
  logic w_div0, w_ovf;
  logic [XLEN-1:0] w_mag_a, w_mag_b, w_byp_result;

  assign w_mop   = (ALUOp == 2'b10) && (Funct7 == 7'b0000001);
  assign md_sel  = in_valid & w_mop;
  assign w_start = md_sel & ~flush & (r_state == S_IDLE);
  assign w_div   = Funct3[2];

  // MUL/MULH signed both, MULHSU signed A only, MULHU unsigned;
  // DIV/REM signed, DIVU/REMU unsigned.
  assign w_a_signed = w_div ? ~Funct3[0] : (Funct3[1:0] != 2'b11);
  assign w_b_signed = w_div ? ~Funct3[0] : ~Funct3[1];
  assign w_sa       = w_a_signed & SrcA[XLEN-1];
  assign w_sb       = w_b_signed & SrcB[XLEN-1];
  assign w_mag_a    = w_sa ? -SrcA : SrcA;
  assign w_mag_b    = w_sb ? -SrcB : SrcB;

  assign w_div0 = w_div && (SrcB == '0);
  assign w_ovf  = w_div && !Funct3[0] &&
                  (SrcA == {1'b1, {(XLEN-1){1'b0}}}) && (SrcB == '1);
  // Funct3[1] selects the remainder form (REM/REMU)
  assign w_byp_result = w_div0 ? (Funct3[1] ? SrcA : '1)
                               : (Funct3[1] ? '0 : SrcA);

  // Shift-add multiply step: multiplier in the low half, product grows from
  // the top as the accumulator shifts right.
  logic [XLEN:0]     w_add;
  logic [2*XLEN-1:0] w_mul_next;
  assign w_add      = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, r_opb};
  assign w_mul_next = r_acc[0] ? {w_add, r_acc[XLEN-1:1]}
                               : {1'b0, r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1:1]};

  // Restoring divide step: {remainder, quotient} shifts left, quotient bit
  // enters at the bottom.
  logic [2*XLEN:0]   w_shl;
  logic [XLEN:0]     w_diff;
  logic [2*XLEN-1:0] w_div_next;
  assign w_shl      = {r_acc, 1'b0};
  assign w_diff     = w_shl[2*XLEN:XLEN] - {1'b0, r_opb};
  assign w_div_next = w_diff[XLEN] ? w_shl[2*XLEN-1:0]
                                   : {w_diff[XLEN-1:0], w_shl[XLEN-1:1], 1'b1};

  logic [2*XLEN-1:0] w_acc_next, w_prod;
  logic [XLEN-1:0]   w_quo, w_rem, w_fin;
  assign w_acc_next = (r_state == S_DIV) ? w_div_next : w_mul_next;
  assign w_prod     = r_neg_q ? -w_acc_next : w_acc_next;
  assign w_quo      = r_neg_q ? -(w_acc_next[XLEN-1:0]) : w_acc_next[XLEN-1:0];
  assign w_rem      = r_neg_r ? -(w_acc_next[2*XLEN-1:XLEN]) : w_acc_next[2*XLEN-1:XLEN];
  assign w_fin      = r_f3[2] ? (r_f3[1] ? w_rem : w_quo)
                              : ((r_f3[1:0] == 2'b00) ? w_prod[XLEN-1:0]
                                                      : w_prod[2*XLEN-1:XLEN]);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_opb       <= '0;
      r_f3        <= '0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_md_result <= '0;
    end else if (flush) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_f3    <= Funct3;
            r_neg_q <= w_sa ^ w_sb;
            r_neg_r <= w_sa;
            r_acc   <= {{XLEN{1'b0}}, (w_div ? w_mag_a : w_mag_b)};
            r_opb   <= w_div ? w_mag_b : w_mag_a;
            if (w_div0 || w_ovf) begin
              r_md_result <= w_byp_result;
              r_cnt       <= '0;
              r_state     <= S_DONE;
            end else begin
              r_cnt   <= CW'(XLEN);
              r_state <= w_div ? S_DIV : S_MUL;
            end
          end
        end
        S_MUL, S_DIV: begin
          r_acc <= w_acc_next;
          if (r_cnt != '0) r_cnt <= r_cnt - CW'(1);
          if (r_cnt <= CW'(1)) begin
            r_md_result <= w_fin;
            r_state     <= S_DONE;
          end
        end
        default: r_state <= S_IDLE;  // DONE lasts exactly one cycle
      endcase
    end
  end

  assign stall     = (md_sel && r_state != S_DONE) ||
                     (r_state == S_MUL) || (r_state == S_DIV);
  assign md_done   = (r_state == S_DONE);
  assign md_result = r_md_result;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_muldiv_alu_ctrl.sv
// Testbench for muldiv_alu_ctrl (XLEN=32): table of directed vectors plus
// hand-written sequences for reset/flush/priority corner cases.
module tb_muldiv_alu_ctrl;
  localparam int XLEN = 32;
  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_MUL  = 2'b01;
  localparam logic [1:0] S_DIV  = 2'b10;
  localparam logic [6:0] F7M    = 7'b0000001;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  logic [1:0]      ALUOp;
  logic [6:0]      Funct7;
  logic [2:0]      Funct3;
  logic            in_valid, flush;
  logic [XLEN-1:0] SrcA, SrcB;
  logic [3:0]      Operation;
  logic            md_sel, stall, md_done;
  logic [XLEN-1:0] md_result;
  logic [1:0]      dbg_state;

  muldiv_alu_ctrl #(.XLEN(XLEN)) dut (
    .clk(clk), .reset(reset), .ALUOp(ALUOp), .Funct7(Funct7), .Funct3(Funct3),
    .in_valid(in_valid), .flush(flush), .SrcA(SrcA), .SrcB(SrcB),
    .Operation(Operation), .md_sel(md_sel), .stall(stall), .md_done(md_done),
    .md_result(md_result), .dbg_state(dbg_state)
  );

  int checks = 0;
  int failures = 0;
  logic [XLEN-1:0] exp_q[$];

  typedef struct {
    string       name;
    logic [1:0]  aluop;
    logic [6:0]  f7;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  exp_op;
    logic [31:0] exp_res;
    int          exp_lat;  // 0 = base ALU only, else cycles to md_done
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input string name, input logic [1:0] aluop,
                              input logic [6:0] f7, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] b,
                              input logic [3:0] op, input logic [31:0] res,
                              input int lat);
    vec_t v;
    v.name = name; v.aluop = aluop; v.f7 = f7; v.f3 = f3; v.a = a; v.b = b;
    v.exp_op = op; v.exp_res = res; v.exp_lat = lat;
    return v;
  endfunction

  // scoreboard compare
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic drive_idle();
    in_valid = 1'b0; flush = 1'b0; ALUOp = 2'b00; Funct7 = '0; Funct3 = '0;
    SrcA = '0; SrcB = '0;
  endtask

  task automatic drive_vec(input vec_t v, input logic valid);
    ALUOp = v.aluop; Funct7 = v.f7; Funct3 = v.f3; SrcA = v.a; SrcB = v.b;
    in_valid = valid;
  endtask

  task automatic check_alu(input vec_t v);
    @(posedge clk); #1;
    drive_vec(v, 1'b0);
    #1;
    chk({v.name, " op"}, 32'(Operation), 32'(v.exp_op));
    chk({v.name, " md_sel(v=0)"}, 32'(md_sel), 32'd0);
    in_valid = 1'b1;
    #1;
    chk({v.name, " md_sel(v=1)"}, 32'(md_sel), 32'd0);
    chk({v.name, " stall(v=1)"}, 32'(stall), 32'd0);
    in_valid = 1'b0;
  endtask

  task automatic run_mop(input vec_t v);
    int done_cyc;
    int stall_cnt;
    logic [31:0] res;
    logic [31:0] exp;
    done_cyc = -1; stall_cnt = 0; res = '0;
    @(posedge clk); #1;
    drive_vec(v, 1'b1);
    exp_q.push_back(v.exp_res);
    @(negedge clk);
    chk({v.name, " op"}, 32'(Operation), 32'(v.exp_op));
    chk({v.name, " md_sel"}, 32'(md_sel), 32'd1);
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (stall) stall_cnt++;
      if (md_done) begin
        done_cyc = cyc;
        res = md_result;
        chk({v.name, " stall_in_done"}, 32'(stall), 32'd0);
        break;
      end
    end
    chk({v.name, " latency"}, 32'(done_cyc), 32'(v.exp_lat));
    chk({v.name, " stall_cycles"}, 32'(stall_cnt), 32'(v.exp_lat));
    exp = exp_q.pop_front();
    chk({v.name, " result"}, res, exp);
    if (done_cyc < 0) begin
      // recover from a hung operation so later vectors still run
      reset = 1'b0; #2; reset = 1'b1;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk({v.name, " idle_after"}, 32'(dbg_state), 32'(S_IDLE));
    chk({v.name, " done_low_after"}, 32'(md_done), 32'd0);
    chk({v.name, " result_held"}, md_result, exp);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    drive_idle();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset state", 32'(dbg_state), 32'(S_IDLE));
    chk("reset md_done", 32'(md_done), 32'd0);
    chk("reset md_result", md_result, 32'd0);
    chk("reset stall", 32'(stall), 32'd0);
    reset = 1'b1;

    // base ALU decode
    vecs.push_back(mk("alu00", 2'b00, 7'h00, 3'b101, 0, 0, 4'b0010, 0, 0));
    vecs.push_back(mk("alu01", 2'b01, 7'h00, 3'b000, 0, 0, 4'b0110, 0, 0));
    vecs.push_back(mk("add", 2'b10, 7'h00, 3'b000, 0, 0, 4'b0010, 0, 0));
    vecs.push_back(mk("add_f7x", 2'b10, 7'h20, 3'b000, 0, 0, 4'b0010, 0, 0));
    vecs.push_back(mk("slt", 2'b10, 7'h00, 3'b010, 0, 0, 4'b1100, 0, 0));
    vecs.push_back(mk("slt_f7x", 2'b10, 7'h20, 3'b010, 0, 0, 4'b0000, 0, 0));
    vecs.push_back(mk("f3_111", 2'b10, 7'h00, 3'b111, 0, 0, 4'b0000, 0, 0));
    vecs.push_back(mk("alu11", 2'b11, 7'h00, 3'b000, 0, 0, 4'b0000, 0, 0));
    // multiply / divide
    vecs.push_back(mk("mul", 2'b10, F7M, 3'b000, 32'd7, 32'hFFFFFFFD, 4'b0000, 32'hFFFFFFEB, 33));
    vecs.push_back(mk("mul_pos", 2'b10, F7M, 3'b000, 32'h12345678, 32'h10, 4'b0000, 32'h23456780, 33));
    vecs.push_back(mk("mulh_pos", 2'b10, F7M, 3'b001, 32'h12345678, 32'h10, 4'b0000, 32'h00000001, 33));
    vecs.push_back(mk("mulh", 2'b10, F7M, 3'b001, 32'h80000000, 32'h80000000, 4'b0000, 32'h40000000, 33));
    vecs.push_back(mk("mulhu", 2'b10, F7M, 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'b0000, 32'hFFFFFFFE, 33));
    vecs.push_back(mk("mulhsu", 2'b10, F7M, 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'b0000, 32'hFFFFFFFF, 33));
    vecs.push_back(mk("div", 2'b10, F7M, 3'b100, 32'hFFFFFFF9, 32'd2, 4'b0000, 32'hFFFFFFFD, 33));
    vecs.push_back(mk("rem", 2'b10, F7M, 3'b110, 32'hFFFFFFF9, 32'd2, 4'b0000, 32'hFFFFFFFF, 33));
    vecs.push_back(mk("div_nb", 2'b10, F7M, 3'b100, 32'd100, 32'hFFFFFFF9, 4'b0000, 32'hFFFFFFF2, 33));
    vecs.push_back(mk("rem_nb", 2'b10, F7M, 3'b110, 32'd100, 32'hFFFFFFF9, 4'b0000, 32'd2, 33));
    vecs.push_back(mk("rem_na", 2'b10, F7M, 3'b110, 32'hFFFFFF9C, 32'd7, 4'b0000, 32'hFFFFFFFE, 33));
    vecs.push_back(mk("divu", 2'b10, F7M, 3'b101, 32'd100, 32'd7, 4'b0000, 32'd14, 33));
    vecs.push_back(mk("remu", 2'b10, F7M, 3'b111, 32'd100, 32'd7, 4'b0000, 32'd2, 33));
    vecs.push_back(mk("divu_z", 2'b10, F7M, 3'b101, 32'd5, 32'd0, 4'b0000, 32'hFFFFFFFF, 1));
    vecs.push_back(mk("div_z", 2'b10, F7M, 3'b100, 32'd6, 32'd0, 4'b0000, 32'hFFFFFFFF, 1));
    vecs.push_back(mk("rem_z", 2'b10, F7M, 3'b110, 32'd5, 32'd0, 4'b0000, 32'd5, 1));
    vecs.push_back(mk("remu_z", 2'b10, F7M, 3'b111, 32'd7, 32'd0, 4'b0000, 32'd7, 1));
    vecs.push_back(mk("div_ovf", 2'b10, F7M, 3'b100, 32'h80000000, 32'hFFFFFFFF, 4'b0000, 32'h80000000, 1));
    vecs.push_back(mk("rem_ovf", 2'b10, F7M, 3'b110, 32'h80000000, 32'hFFFFFFFF, 4'b0000, 32'd0, 1));

    foreach (vecs[i]) begin
      if (vecs[i].exp_lat == 0) check_alu(vecs[i]);
      else run_mop(vecs[i]);
    end

    // reset asserted at cycle 10 of a MUL
    @(posedge clk); #1;
    drive_vec(vecs[8], 1'b1);
    repeat (10) @(posedge clk);
    #1;
    chk("rst_mid pre_state", 32'(dbg_state), 32'(S_MUL));
    #2;
    reset = 1'b0;
    #1;
    chk("rst_mid state", 32'(dbg_state), 32'(S_IDLE));
    chk("rst_mid md_done", 32'(md_done), 32'd0);
    chk("rst_mid md_result", md_result, 32'd0);
    chk("rst_mid stall=md_sel", 32'(stall), 32'd1);
    in_valid = 1'b0;
    #1;
    chk("rst_mid stall idle", 32'(stall), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (md_done) seen = 1'b1;
    end
    chk("rst_mid no_done", 32'(seen), 32'd0);

    // flush at cycle 5 of a DIV
    @(posedge clk); #1;
    drive_vec(vecs[14], 1'b1);
    repeat (5) @(posedge clk);
    #1;
    chk("flush pre_state", 32'(dbg_state), 32'(S_DIV));
    flush = 1'b1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush state", 32'(dbg_state), 32'(S_IDLE));
    chk("flush md_done", 32'(md_done), 32'd0);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (md_done) seen = 1'b1;
    end
    chk("flush no_done", 32'(seen), 32'd0);
    run_mop(vecs[19]);  // DIVU 100/7 after the flush

    // flush beats a simultaneous start
    @(posedge clk); #1;
    drive_vec(vecs[8], 1'b1);
    flush = 1'b1;
    @(posedge clk); #1;
    chk("flush_prio state", 32'(dbg_state), 32'(S_IDLE));
    drive_idle();
    @(negedge clk);
    chk("flush_prio md_done", 32'(md_done), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
